// File: rtl/servo_bank.sv
// NUM_CH-channel 50 Hz servo PWM on the 8-bit bus; positions/enables are double-buffered and applied at frame start.
// Latency: reads 1 cycle, pins 1 cycle behind the frame counter; no backpressure (bus accesses always accepted).
module servo_bank #(
  parameter int         CLK_FREQ     = 16000000,
  parameter int         NUM_CH       = 4,
  parameter logic [7:0] BASE_ADDRESS = 8'h00,
  parameter int         FRAME_TICKS  = 3150,
  parameter int         MIN_TICKS    = 91
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        din,
  input  logic [7:0]        address,
  input  logic              w_en,
  input  logic              r_en,
  output logic [7:0]        dout,
  output logic [NUM_CH-1:0] servo_pin
);
  // ceil(6.35us * CLK_FREQ), in 64 bits so fast clocks do not overflow
  localparam longint TICK_DIV_L = (longint'(CLK_FREQ) * 64'd635 + 64'd99_999_999) / 64'd100_000_000;
  localparam int TICK_DIV = int'(TICK_DIV_L);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(FRAME_TICKS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(FRAME_TICKS - 1);
  localparam logic [CW:0]   MIN_W      = (CW+1)'(MIN_TICKS);

  logic [PW-1:0]     presc;
  logic              tick;
  logic [CW-1:0]     cnt;
  logic              pending;
  logic              parity;
  logic [7:0]        pos_sh  [NUM_CH];
  logic [7:0]        pos_act [NUM_CH];
  logic [NUM_CH-1:0] en_sh;
  logic [NUM_CH-1:0] en_act;
  logic [7:0]        off;
  logic              is_pos;
  logic              is_en;
  logic              is_stat;
  logic              frame_start;
  logic [7:0]        rd_val;

  assign off         = address - BASE_ADDRESS;
  assign is_pos      = off < 8'(NUM_CH);
  assign is_en       = off == 8'(NUM_CH);
  assign is_stat     = off == 8'(NUM_CH + 1);
  assign frame_start = tick && (cnt == CNT_LAST);

  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < NUM_CH; i++)
      if (off == 8'(i)) rd_val = pos_sh[i];
    if (is_en)   rd_val[NUM_CH-1:0] = en_sh;
    if (is_stat) rd_val = {6'b0, parity, pending};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      tick      <= 1'b0;
      cnt       <= '0;
      pending   <= 1'b0;
      parity    <= 1'b0;
      dout      <= 8'h00;
      servo_pin <= '0;
      en_sh     <= '0;
      en_act    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pos_sh[i]  <= 8'h80;
        pos_act[i] <= 8'h80;
      end
    end else begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
      tick  <= (presc == PRESC_LAST);
      if (tick) cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);

      if (frame_start) begin
        for (int i = 0; i < NUM_CH; i++) pos_act[i] <= pos_sh[i];
        en_act  <= en_sh;
        pending <= 1'b0;
        parity  <= ~parity;
      end

      // A write on the frame-start edge misses this transfer and stays pending.
      if (w_en && (is_pos || is_en)) pending <= 1'b1;
      if (w_en && is_en) en_sh <= din[NUM_CH-1:0];
      for (int i = 0; i < NUM_CH; i++)
        if (w_en && off == 8'(i)) pos_sh[i] <= din;

      dout <= r_en ? rd_val : 8'h00;

      for (int i = 0; i < NUM_CH; i++)
        servo_pin[i] <= en_act[i] && ({1'b0, cnt} < MIN_W + (CW+1)'(pos_act[i]));
    end
  end
endmodule

// File: tb/tb_servo_bank.sv
// Bench for servo_bank: directed scenarios plus random bus traffic against a cycle-count reference model.
module tb_servo_bank;
  localparam int         CF   = 1000000;
  localparam int         NCH  = 4;
  localparam logic [7:0] BASE = 8'h20;
  localparam int         FT   = 300;
  localparam int         MT   = 10;
  localparam int         TD   = 7;
  localparam int         FC   = FT * TD;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [7:0]       din = 8'h00;
  logic [7:0]       address = 8'h00;
  logic             w_en = 1'b0;
  logic             r_en = 1'b0;
  logic [7:0]       dout;
  logic [NCH-1:0]   servo_pin;

  servo_bank #(
    .CLK_FREQ(CF), .NUM_CH(NCH), .BASE_ADDRESS(BASE), .FRAME_TICKS(FT), .MIN_TICKS(MT)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
    .dout(dout), .servo_pin(servo_pin)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: cycle index since the last reset edge drives all timing.
  int           m_n;
  int           m_pos_sh  [NCH];
  int           m_pos_act [NCH];
  bit [NCH-1:0] m_en_sh, m_en_act;
  bit           m_pend, m_par;
  bit [NCH-1:0] m_pin;
  bit [7:0]     m_dout;

  int wid [NCH];
  int period;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Tick number within the frame after n cycles since reset.
  function automatic int frame_tick(input int n);
    return (n == 0) ? 0 : ((n - 1) / TD) % FT;
  endfunction

  function automatic bit [7:0] reg_read(input bit [7:0] a);
    int o;
    o = int'(a) - int'(BASE);
    if (o >= 0 && o < NCH) return 8'(m_pos_sh[o]);
    if (o == NCH)          return 8'(m_en_sh);
    if (o == NCH + 1)      return {6'b0, m_par, m_pend};
    return 8'h00;
  endfunction

  task automatic model_edge(input bit r, input bit w, input bit rd, input bit [7:0] a, input bit [7:0] d);
    bit [NCH-1:0] nxt_pin;
    bit [7:0]     nxt_dout;
    int           nn, o;
    if (r) begin
      m_n = 0; m_en_sh = '0; m_en_act = '0; m_pend = 0; m_par = 0; m_pin = '0; m_dout = 8'h00;
      for (int i = 0; i < NCH; i++) begin m_pos_sh[i] = 128; m_pos_act[i] = 128; end
      return;
    end
    for (int i = 0; i < NCH; i++)
      nxt_pin[i] = m_en_act[i] && (frame_tick(m_n) < MT + m_pos_act[i]);
    nxt_dout = rd ? reg_read(a) : 8'h00;
    nn = m_n + 1;
    if (nn > 1 && (nn - 1) % FC == 0) begin
      for (int i = 0; i < NCH; i++) m_pos_act[i] = m_pos_sh[i];
      m_en_act = m_en_sh;
      m_pend = 0;
      m_par = ~m_par;
    end
    o = int'(a) - int'(BASE);
    if (w && o >= 0 && o < NCH) begin m_pos_sh[o] = int'(d); m_pend = 1; end
    else if (w && o == NCH) begin m_en_sh = d[NCH-1:0]; m_pend = 1; end
    m_n = nn;
    m_pin = nxt_pin;
    m_dout = nxt_dout;
  endtask

  task automatic cyc(input bit r, input bit w, input bit rd, input bit [7:0] a, input bit [7:0] d);
    rst = r; w_en = w; r_en = rd; address = a; din = d;
    @(posedge clk);
    model_edge(r, w, rd, a, d);
    #1;
    check("pins", 32'(servo_pin), 32'(m_pin));
    check("dout", 32'(dout), 32'(m_dout));
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic wr(input int o, input bit [7:0] d);
    cyc(1'b0, 1'b1, 1'b0, 8'(int'(BASE) + o), d);
  endtask

  task automatic rd(input int o);
    cyc(1'b0, 1'b0, 1'b1, 8'(int'(BASE) + o), 8'h00);
  endtask

  // Advance to the first cycle of the next pulse group (pins rising from all-low).
  task automatic to_rise();
    int b = 0;
    while (servo_pin != '0 && b < 2 * FC) begin idle(); b++; end
    while (servo_pin == '0 && b < 4 * FC) begin idle(); b++; end
    check("rise_seen", 32'(servo_pin != '0), 32'd1);
  endtask

  // Starting on a rise: count high cycles per pin over one frame, then find the next rise.
  task automatic frame_widths();
    for (int i = 0; i < NCH; i++) wid[i] = 0;
    for (int k = 0; k < FC; k++) begin
      for (int i = 0; i < NCH; i++) if (servo_pin[i]) wid[i]++;
      idle();
    end
    period = FC;
    while (servo_pin == '0 && period < 2 * FC) begin idle(); period++; end
  endtask

  initial begin
    int b;
    bit r, w, rv;
    bit [7:0] a;

    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    check("rst_pins", 32'(servo_pin), 32'd0);
    rd(0);
    check("pos0_rst", 32'(dout), 32'h80);
    rd(NCH + 1);
    check("stat_rst", 32'(dout), 32'h00);
    repeat (2 * FC + 100) idle();
    check("idle_pins", 32'(servo_pin), 32'd0);

    // Channel 1 enabled mid-frame: no pulse until the next frame
    wr(1, 8'd20);
    wr(NCH, 8'h02);
    rd(NCH + 1);
    check("stat_pend", 32'(dout[0]), 32'd1);
    to_rise();
    check("p1_rise", 32'(servo_pin), 32'h2);
    rd(NCH + 1);
    check("stat_clr", 32'(dout[0]), 32'd0);
    frame_widths();
    check("p1_high", 32'(wid[1]), 32'd210);
    check("p1_low", 32'(period - wid[1]), 32'd1890);
    check("period", 32'(period), 32'd2100);

    // Extreme positions on channels 0 and 3
    wr(0, 8'd0);
    wr(3, 8'd255);
    wr(NCH, 8'h09);
    to_rise();
    check("p03_rise", 32'(servo_pin), 32'h9);
    frame_widths();
    check("p0_min", 32'(wid[0]), 32'd70);
    check("p3_max", 32'(wid[3]), 32'd1855);
    wr(NCH, 8'hFF);
    rd(NCH);
    check("en_mask", 32'(dout), 32'h0F);
    cyc(1'b0, 1'b1, 1'b1, 8'(int'(BASE) + 1), 8'd99);
    check("rw_same", 32'(dout), 32'd20);
    rd(1);
    check("pos1_new", 32'(dout), 32'd99);

    // Write exactly on a frame-start edge
    b = 0;
    while (!(m_n > 0 && m_n % FC == 0) && b < 3 * FC) begin idle(); b++; end
    wr(0, 8'd50);
    to_rise();
    frame_widths();
    check("p0_old", 32'(wid[0]), 32'd70);
    frame_widths();
    check("p0_new", 32'(wid[0]), 32'd420);

    // Reset mid-pulse with a simultaneous write
    repeat (10) idle();
    check("p2_high", 32'(servo_pin[2]), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 8'(int'(BASE) + 2), 8'd5);
    check("p2_rst", 32'(servo_pin[2]), 32'd0);
    rd(2);
    check("pos2_rst", 32'(dout), 32'h80);
    rd(NCH);
    check("en_rst", 32'(dout), 32'h00);

    // Unmapped read, status write, write below base
    rd(NCH + 2);
    check("unmapped", 32'(dout), 32'h00);
    wr(NCH + 1, 8'hFF);
    rd(NCH + 1);
    check("stat_ro", 32'(dout), 32'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h10, 8'h55);
    rd(0);
    check("pos0_keep", 32'(dout), 32'h80);

    // Random bus traffic
    repeat (15000) begin
      r  = ($urandom_range(0, 2999) == 0);
      w  = ($urandom_range(0, 39) == 0);
      rv = ($urandom_range(0, 2) == 0);
      a  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(int'(BASE) + int'($urandom_range(0, 7)));
      cyc(r, w, rv, a, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
